// File: rtl/button_press_decoder_if.sv
// Button decoder bus: raw pin and thresholds in, debounced status and press results out.
interface button_press_decoder_if;
  logic        BTN;
  logic [31:0] debounce_time;
  logic [31:0] long_time;
  logic        BTN_STS;
  logic        hold_active;
  logic        press_short;
  logic        press_long;
  logic [31:0] press_duration;
  logic [15:0] press_count;

  // Board/PS side: drives the pin and thresholds, polls the results.
  modport master (
    output BTN, debounce_time, long_time,
    input  BTN_STS, hold_active, press_short, press_long, press_duration, press_count
  );

  // Decoder side.
  modport slave (
    input  BTN, debounce_time, long_time,
    output BTN_STS, hold_active, press_short, press_long, press_duration, press_count
  );
endinterface

// File: rtl/button_press_decoder.sv
// Push-button decoder: synchronises and debounces one raw pin, then classifies each
// completed press as short or long and keeps duration/count for register polling.
module button_press_decoder #(
  parameter bit          INVERSE_MODE = 1'b1,  // 1: pin pressed = 0
  parameter int unsigned SYNC_STAGES  = 2      // must be >= 2
) (
  input logic                   clk,
  input logic                   resetn,
  button_press_decoder_if.slave bus_io
);

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StDbPress   = 2'd1,
    StPressed   = 2'd2,
    StDbRelease = 2'd3
  } state_e;

  localparam logic [31:0] TimerMax = 32'hFFFF_FFFF;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   btn_act;

  state_e      state_q, state_d;
  logic [31:0] db_timer_q, db_timer_d;
  logic [31:0] press_timer_q, press_timer_d;
  logic [31:0] press_duration_q, press_duration_d;
  logic [15:0] press_count_q, press_count_d;
  logic        press_short_q, press_short_d;
  logic        press_long_q, press_long_d;
  logic        complete;
  logic        btn_sts;

  // Synchroniser shifts the raw pin in; reset to the idle pin level so release looks quiet.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus_io.BTN};
  end

  assign btn_act = sync_q[SYNC_STAGES-1] ^ INVERSE_MODE;

  // State register: synchroniser, FSM, timers and press results.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q           <= {SYNC_STAGES{INVERSE_MODE}};
      state_q          <= StIdle;
      db_timer_q       <= '0;
      press_timer_q    <= '0;
      press_duration_q <= '0;
      press_count_q    <= '0;
      press_short_q    <= 1'b0;
      press_long_q     <= 1'b0;
    end else begin
      sync_q           <= sync_d;
      state_q          <= state_d;
      db_timer_q       <= db_timer_d;
      press_timer_q    <= press_timer_d;
      press_duration_q <= press_duration_d;
      press_count_q    <= press_count_d;
      press_short_q    <= press_short_d;
      press_long_q     <= press_long_d;
    end
  end

  // Next-state: debounce both edges of a press and time the press while it is held.
  always_comb begin
    state_d       = state_q;
    db_timer_d    = db_timer_q;
    press_timer_d = press_timer_q;
    complete      = 1'b0;

    // The press timer runs through release debounce so glitches do not lose time.
    if ((state_q == StPressed || state_q == StDbRelease) && press_timer_q != TimerMax) begin
      press_timer_d = press_timer_q + 32'd1;
    end

    unique case (state_q)
      StIdle: begin
        db_timer_d = '0;
        if (btn_act) state_d = StDbPress;
      end
      StDbPress: begin
        if (!btn_act) begin
          state_d    = StIdle;
          db_timer_d = '0;
        end else if (db_timer_q >= bus_io.debounce_time) begin
          state_d       = StPressed;
          db_timer_d    = '0;
          press_timer_d = '0;
        end else begin
          db_timer_d = db_timer_q + 32'd1;
        end
      end
      StPressed: begin
        db_timer_d = '0;
        if (!btn_act) state_d = StDbRelease;
      end
      StDbRelease: begin
        if (btn_act) begin
          state_d    = StPressed;
          db_timer_d = '0;
        end else if (db_timer_q >= bus_io.debounce_time) begin
          state_d    = StIdle;
          db_timer_d = '0;
          complete   = 1'b1;
        end else begin
          db_timer_d = db_timer_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Completion latches the pre-edge press time and fires exactly one class pulse.
    press_short_d    = complete && (press_timer_q < bus_io.long_time);
    press_long_d     = complete && (press_timer_q >= bus_io.long_time);
    press_duration_d = complete ? press_timer_q : press_duration_q;
    press_count_d    = complete ? press_count_q + 16'd1 : press_count_q;
  end

  // Outputs: debounced level is state-decoded, hold status compares the live threshold.
  always_comb begin
    btn_sts            = (state_q == StPressed) || (state_q == StDbRelease);
    bus_io.BTN_STS     = btn_sts;
    bus_io.hold_active = btn_sts && (press_timer_q >= bus_io.long_time);
    bus_io.press_short    = press_short_q;
    bus_io.press_long     = press_long_q;
    bus_io.press_duration = press_duration_q;
    bus_io.press_count    = press_count_q;
  end

endmodule

// File: tb/tb_button_press_decoder.sv
// Self-checking bench for button_press_decoder: an active-low and an active-high instance,
// expected press completions queued at stimulus time and popped when a pulse appears.
module tb_button_press_decoder;

  logic clk = 1'b0;
  logic resetn = 1'b1;

  always #5 clk = ~clk;

  button_press_decoder_if bus0 ();
  button_press_decoder_if bus1 ();

  button_press_decoder #(
    .INVERSE_MODE(1'b1),
    .SYNC_STAGES (2)
  ) u_dut0 (
    .clk   (clk),
    .resetn(resetn),
    .bus_io(bus0)
  );

  button_press_decoder #(
    .INVERSE_MODE(1'b0),
    .SYNC_STAGES (2)
  ) u_dut1 (
    .clk   (clk),
    .resetn(resetn),
    .bus_io(bus1)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct packed {
    logic        is_long;
    logic [31:0] dur;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  // Scoreboard for the active-low instance.
  always @(negedge clk) begin
    exp_t e;
    if (resetn && (bus0.press_short || bus0.press_long)) begin
      checks++;
      if (exp_q0.size() == 0) begin
        errors++;
        $display("FAIL sb0_unexpected: short=%0b long=%0b dur=%0d cnt=%0d, wanted no pulse",
                 bus0.press_short, bus0.press_long, bus0.press_duration, bus0.press_count);
      end else begin
        e = exp_q0.pop_front();
        if ({bus0.press_short, bus0.press_long, bus0.press_duration, bus0.press_count} !==
            {~e.is_long, e.is_long, e.dur, e.cnt}) begin
          errors++;
          $display("FAIL sb0_press: short=%0b long=%0b dur=%0d cnt=%0d, want short=%0b long=%0b dur=%0d cnt=%0d",
                   bus0.press_short, bus0.press_long, bus0.press_duration, bus0.press_count,
                   ~e.is_long, e.is_long, e.dur, e.cnt);
        end
      end
    end
  end

  // Scoreboard for the active-high instance.
  always @(negedge clk) begin
    exp_t e;
    if (resetn && (bus1.press_short || bus1.press_long)) begin
      checks++;
      if (exp_q1.size() == 0) begin
        errors++;
        $display("FAIL sb1_unexpected: short=%0b long=%0b dur=%0d cnt=%0d, wanted no pulse",
                 bus1.press_short, bus1.press_long, bus1.press_duration, bus1.press_count);
      end else begin
        e = exp_q1.pop_front();
        if ({bus1.press_short, bus1.press_long, bus1.press_duration, bus1.press_count} !==
            {~e.is_long, e.is_long, e.dur, e.cnt}) begin
          errors++;
          $display("FAIL sb1_press: short=%0b long=%0b dur=%0d cnt=%0d, want short=%0b long=%0b dur=%0d cnt=%0d",
                   bus1.press_short, bus1.press_long, bus1.press_duration, bus1.press_count,
                   ~e.is_long, e.is_long, e.dur, e.cnt);
        end
      end
    end
  end

  task automatic apply_reset();
    resetn   = 1'b0;
    bus0.BTN = 1'b1;
    bus1.BTN = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    bus0.BTN = 1'b1;
    bus1.BTN = 1'b0;
    bus0.debounce_time = 32'd3;
    bus0.long_time     = 32'd1000;
    bus1.debounce_time = 32'd0;
    bus1.long_time     = 32'd5;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus0.BTN_STS, bus0.hold_active, bus0.press_short, bus0.press_long,
         bus0.press_duration, bus0.press_count} !== 52'd0) begin
      errors++;
      $display("FAIL reset0_in_reset: sts=%0b hold=%0b dur=%0d cnt=%0d, want all 0",
               bus0.BTN_STS, bus0.hold_active, bus0.press_duration, bus0.press_count);
    end
    checks++;
    if ({bus1.BTN_STS, bus1.hold_active, bus1.press_short, bus1.press_long,
         bus1.press_duration, bus1.press_count} !== 52'd0) begin
      errors++;
      $display("FAIL reset1_in_reset: sts=%0b hold=%0b dur=%0d cnt=%0d, want all 0",
               bus1.BTN_STS, bus1.hold_active, bus1.press_duration, bus1.press_count);
    end
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if ({bus0.BTN_STS, bus0.hold_active, bus0.press_count} !== 18'd0) begin
      errors++;
      $display("FAIL reset0_idle: sts=%0b hold=%0b cnt=%0d, want all 0",
               bus0.BTN_STS, bus0.hold_active, bus0.press_count);
    end
    checks++;
    if ({bus1.BTN_STS, bus1.hold_active, bus1.press_count} !== 18'd0) begin
      errors++;
      $display("FAIL reset1_idle: sts=%0b hold=%0b cnt=%0d, want all 0",
               bus1.BTN_STS, bus1.hold_active, bus1.press_count);
    end
  endtask

  task automatic test_short_press();
    logic exp_sts;
    apply_reset();
    bus0.debounce_time = 32'd3;
    bus0.long_time     = 32'd1000;
    exp_q0.push_back('{is_long: 1'b0, dur: 32'd99, cnt: 16'd1});
    for (int k = 1; k <= 115; k++) begin
      bus0.BTN = (k <= 100) ? 1'b0 : 1'b1;
      @(posedge clk);
      @(negedge clk);
      exp_sts = (k >= 7 && k <= 106);
      checks++;
      if (bus0.BTN_STS !== exp_sts) begin
        errors++;
        $display("FAIL short_sts edge %0d: got %0b want %0b", k, bus0.BTN_STS, exp_sts);
      end
      if (k == 107) begin
        checks++;
        if (bus0.press_short !== 1'b1) begin
          errors++;
          $display("FAIL short_pulse_time edge %0d: got %0b want 1", k, bus0.press_short);
        end
      end
    end
    checks++;
    if (exp_q0.size() != 0) begin
      errors++;
      $display("FAIL short_missing: %0d pending, want 0", exp_q0.size());
    end
    checks++;
    if ({bus0.press_duration, bus0.press_count} !== {32'd99, 16'd1}) begin
      errors++;
      $display("FAIL short_regs: dur=%0d cnt=%0d want dur=99 cnt=1",
               bus0.press_duration, bus0.press_count);
    end
  endtask

  task automatic test_reject();
    logic exp_sts;
    apply_reset();
    bus0.debounce_time = 32'd3;
    bus0.long_time     = 32'd1000;
    for (int k = 1; k <= 20; k++) begin
      bus0.BTN = (k <= 4) ? 1'b0 : 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus0.BTN_STS !== 1'b0) begin
        errors++;
        $display("FAIL reject_sts edge %0d: got %0b want 0", k, bus0.BTN_STS);
      end
    end
    checks++;
    if (bus0.press_count !== 16'd0) begin
      errors++;
      $display("FAIL reject_cnt: got %0d want 0", bus0.press_count);
    end
    exp_q0.push_back('{is_long: 1'b0, dur: 32'd4, cnt: 16'd1});
    for (int k = 1; k <= 20; k++) begin
      bus0.BTN = (k <= 5) ? 1'b0 : 1'b1;
      @(posedge clk);
      @(negedge clk);
      exp_sts = (k >= 7 && k <= 11);
      checks++;
      if (bus0.BTN_STS !== exp_sts) begin
        errors++;
        $display("FAIL accept5_sts edge %0d: got %0b want %0b", k, bus0.BTN_STS, exp_sts);
      end
    end
    checks++;
    if (exp_q0.size() != 0 || bus0.press_count !== 16'd1 || bus0.press_duration !== 32'd4) begin
      errors++;
      $display("FAIL accept5_regs: pending=%0d dur=%0d cnt=%0d want 0/4/1",
               exp_q0.size(), bus0.press_duration, bus0.press_count);
    end
  endtask

  task automatic test_long_hold();
    logic exp_sts;
    logic exp_hold;
    apply_reset();
    bus0.debounce_time = 32'd3;
    bus0.long_time     = 32'd50;
    exp_q0.push_back('{is_long: 1'b1, dur: 32'd199, cnt: 16'd1});
    for (int k = 1; k <= 215; k++) begin
      bus0.BTN = (k <= 200) ? 1'b0 : 1'b1;
      @(posedge clk);
      @(negedge clk);
      exp_sts  = (k >= 7 && k <= 206);
      exp_hold = (k >= 57 && k <= 206);
      checks++;
      if ({bus0.BTN_STS, bus0.hold_active} !== {exp_sts, exp_hold}) begin
        errors++;
        $display("FAIL long_sts_hold edge %0d: got sts=%0b hold=%0b want sts=%0b hold=%0b",
                 k, bus0.BTN_STS, bus0.hold_active, exp_sts, exp_hold);
      end
      if (k == 207) begin
        checks++;
        if ({bus0.press_long, bus0.press_short} !== 2'b10) begin
          errors++;
          $display("FAIL long_pulse edge %0d: got long=%0b short=%0b want long=1 short=0",
                   k, bus0.press_long, bus0.press_short);
        end
      end
    end
    checks++;
    if (exp_q0.size() != 0 || bus0.press_duration !== 32'd199) begin
      errors++;
      $display("FAIL long_regs: pending=%0d dur=%0d want 0/199", exp_q0.size(), bus0.press_duration);
    end
  endtask

  task automatic test_glitch();
    logic exp_sts;
    apply_reset();
    bus0.debounce_time = 32'd3;
    bus0.long_time     = 32'd1000;
    exp_q0.push_back('{is_long: 1'b0, dur: 32'd99, cnt: 16'd1});
    for (int k = 1; k <= 115; k++) begin
      bus0.BTN = (k <= 100 && k != 40 && k != 41) ? 1'b0 : 1'b1;
      @(posedge clk);
      @(negedge clk);
      exp_sts = (k >= 7 && k <= 106);
      checks++;
      if (bus0.BTN_STS !== exp_sts) begin
        errors++;
        $display("FAIL glitch_sts edge %0d: got %0b want %0b", k, bus0.BTN_STS, exp_sts);
      end
    end
    checks++;
    if (exp_q0.size() != 0 || bus0.press_count !== 16'd1 || bus0.press_duration !== 32'd99) begin
      errors++;
      $display("FAIL glitch_regs: pending=%0d dur=%0d cnt=%0d want 0/99/1",
               exp_q0.size(), bus0.press_duration, bus0.press_count);
    end
  endtask

  // Runs straight after test_glitch so the count starts at 1 and reset must clear it.
  task automatic test_reset_mid_press();
    logic exp_sts;
    bus0.debounce_time = 32'd3;
    bus0.long_time     = 32'd1000;
    for (int k = 1; k <= 50; k++) begin
      bus0.BTN = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (bus0.BTN_STS !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre_sts: got %0b want 1", bus0.BTN_STS);
    end
    resetn   = 1'b0;
    bus0.BTN = 1'b1;
    #1;
    checks++;
    if ({bus0.BTN_STS, bus0.hold_active, bus0.press_short, bus0.press_long,
         bus0.press_duration, bus0.press_count} !== 52'd0) begin
      errors++;
      $display("FAIL midrst_clear: sts=%0b hold=%0b dur=%0d cnt=%0d want all 0",
               bus0.BTN_STS, bus0.hold_active, bus0.press_duration, bus0.press_count);
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus0.BTN_STS, bus0.press_count} !== 17'd0) begin
        errors++;
        $display("FAIL midrst_quiet cycle %0d: sts=%0b cnt=%0d want 0/0",
                 k, bus0.BTN_STS, bus0.press_count);
      end
    end
    exp_q0.push_back('{is_long: 1'b0, dur: 32'd99, cnt: 16'd1});
    for (int k = 1; k <= 115; k++) begin
      bus0.BTN = (k <= 100) ? 1'b0 : 1'b1;
      @(posedge clk);
      @(negedge clk);
      exp_sts = (k >= 7 && k <= 106);
      checks++;
      if (bus0.BTN_STS !== exp_sts) begin
        errors++;
        $display("FAIL midrst_new_sts edge %0d: got %0b want %0b", k, bus0.BTN_STS, exp_sts);
      end
    end
    checks++;
    if (exp_q0.size() != 0 || bus0.press_count !== 16'd1 || bus0.press_duration !== 32'd99) begin
      errors++;
      $display("FAIL midrst_new_regs: pending=%0d dur=%0d cnt=%0d want 0/99/1",
               exp_q0.size(), bus0.press_duration, bus0.press_count);
    end
  endtask

  task automatic test_active_high();
    logic exp_sts;
    apply_reset();
    bus1.debounce_time = 32'd0;
    bus1.long_time     = 32'd5;
    for (int k = 1; k <= 20; k++) begin
      bus1.BTN = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus1.BTN_STS, bus1.press_count} !== 17'd0) begin
        errors++;
        $display("FAIL ah_idle cycle %0d: sts=%0b cnt=%0d want 0/0", k, bus1.BTN_STS,
                 bus1.press_count);
      end
    end
    exp_q1.push_back('{is_long: 1'b0, dur: 32'd2, cnt: 16'd1});
    for (int k = 1; k <= 15; k++) begin
      bus1.BTN = (k <= 3) ? 1'b1 : 1'b0;
      @(posedge clk);
      @(negedge clk);
      exp_sts = (k >= 4 && k <= 6);
      checks++;
      if (bus1.BTN_STS !== exp_sts) begin
        errors++;
        $display("FAIL ah_w3_sts edge %0d: got %0b want %0b", k, bus1.BTN_STS, exp_sts);
      end
      if (k == 7) begin
        checks++;
        if (bus1.press_short !== 1'b1) begin
          errors++;
          $display("FAIL ah_w3_pulse edge %0d: got %0b want 1", k, bus1.press_short);
        end
      end
    end
    for (int k = 1; k <= 15; k++) begin
      bus1.BTN = (k <= 1) ? 1'b1 : 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus1.BTN_STS !== 1'b0) begin
        errors++;
        $display("FAIL ah_w1_sts edge %0d: got %0b want 0", k, bus1.BTN_STS);
      end
    end
    checks++;
    if (exp_q1.size() != 0 || bus1.press_count !== 16'd1 || bus1.press_duration !== 32'd2) begin
      errors++;
      $display("FAIL ah_regs: pending=%0d dur=%0d cnt=%0d want 0/2/1",
               exp_q1.size(), bus1.press_duration, bus1.press_count);
    end
  endtask

  // Continues on the active-high instance: a zero long threshold makes every press long.
  task automatic test_zero_long();
    logic exp_sts;
    bus1.debounce_time = 32'd0;
    bus1.long_time     = 32'd0;
    exp_q1.push_back('{is_long: 1'b1, dur: 32'd2, cnt: 16'd2});
    for (int k = 1; k <= 15; k++) begin
      bus1.BTN = (k <= 3) ? 1'b1 : 1'b0;
      @(posedge clk);
      @(negedge clk);
      exp_sts = (k >= 4 && k <= 6);
      checks++;
      if ({bus1.BTN_STS, bus1.hold_active} !== {exp_sts, exp_sts}) begin
        errors++;
        $display("FAIL zl_sts_hold edge %0d: got sts=%0b hold=%0b want %0b/%0b",
                 k, bus1.BTN_STS, bus1.hold_active, exp_sts, exp_sts);
      end
      if (k == 7) begin
        checks++;
        if ({bus1.press_long, bus1.press_short} !== 2'b10) begin
          errors++;
          $display("FAIL zl_pulse edge %0d: got long=%0b short=%0b want 1/0",
                   k, bus1.press_long, bus1.press_short);
        end
      end
    end
    checks++;
    if (exp_q1.size() != 0 || bus1.press_count !== 16'd2) begin
      errors++;
      $display("FAIL zl_regs: pending=%0d cnt=%0d want 0/2", exp_q1.size(), bus1.press_count);
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_reject();
    test_long_hold();
    test_glitch();
    test_reset_mid_press();
    test_active_high();
    test_zero_long();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
